// File: rtl/calc_sequencer.sv
// calc_sequencer: debounces three push buttons, captures switch operands, issues an
// add/subtract request to an external ALU over a valid/ready handshake, waits for the
// result with a timeout, and selects what the display shows.
// Optional build macro CALC_CHAIN_EN: an add/subtract press while a result is shown
// reuses that result as the first operand of a new request.
module calc_sequencer #(
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned RES_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  bin,
  input  logic        buttonU,
  input  logic        buttonR,
  input  logic        buttonL,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_code,
  output logic [10:0] op_a,
  output logic [10:0] op_b,
  input  logic        res_valid,
  input  logic [10:0] res_data,
  output logic [10:0] disp_value,
  output logic [1:0]  disp_mode,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DbCntW = $clog2(DB_CYCLES + 1);
  localparam int unsigned TmoCntW = $clog2(RES_TIMEOUT + 1);
  localparam logic [DbCntW-1:0] DbLast = DbCntW'(DB_CYCLES - 1);
  localparam logic [TmoCntW-1:0] TmoLast = TmoCntW'(RES_TIMEOUT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHaveA   = 3'd1;
  localparam logic [2:0] StIssue   = 3'd2;
  localparam logic [2:0] StWaitRes = 3'd3;
  localparam logic [2:0] StShow    = 3'd4;

  // Button index: 2 = U (save), 1 = R (add), 0 = L (subtract).
  logic [2:0]        sync1_q, sync2_q, db_q, press_q;
  logic [DbCntW-1:0] db_cnt_q [3];
  logic              press_u, press_r, press_l;

  logic [2:0]         state_q, state_d;
  logic [TmoCntW-1:0] tmo_cnt_q;
  logic [10:0]        result_q;

  // Synchronize and debounce; press_q pulses for one cycle when a level is accepted high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= {buttonU, buttonR, buttonL};
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
            press_q[i]  <= sync2_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Coincident presses resolve U > R > L; losers are simply dropped.
  assign press_u = press_q[2];
  assign press_r = press_q[1] & ~press_q[2];
  assign press_l = press_q[0] & ~press_q[2] & ~press_q[1];

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (press_u) state_d = StHaveA;
      StHaveA: if (press_r || press_l) state_d = StIssue;
      StIssue: if (op_ready) state_d = StWaitRes;
      StWaitRes: begin
        // A result arriving in the last allowed cycle beats the timeout.
        if (res_valid) state_d = StShow;
        else if (tmo_cnt_q == TmoLast) state_d = StIdle;
      end
      StShow: begin
        if (press_u) state_d = StHaveA;
`ifdef CALC_CHAIN_EN
        else if (press_r || press_l) state_d = StIssue;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand, result, timeout and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= 1'b0;
      result_q  <= '0;
      err       <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle, StShow: begin
          if (press_u) begin
            op_a <= {1'b0, bin};
            err  <= 1'b0;
          end
`ifdef CALC_CHAIN_EN
          else if (state_q == StShow && (press_r || press_l)) begin
            op_a    <= result_q;
            op_b    <= {1'b0, bin};
            op_code <= press_l;
          end
`endif
        end
        StHaveA: begin
          if (press_u) begin
            op_a <= {1'b0, bin};
          end else if (press_r || press_l) begin
            op_b    <= {1'b0, bin};
            op_code <= press_l;
          end
        end
        StIssue: tmo_cnt_q <= '0;
        StWaitRes: begin
          if (res_valid) begin
            result_q <= res_data;
          end else if (tmo_cnt_q == TmoLast) begin
            err <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake, busy and display selection decode straight from state.
  always_comb begin
    op_valid   = (state_q == StIssue);
    busy       = (state_q == StIssue) || (state_q == StWaitRes);
    disp_mode  = 2'd0;
    disp_value = {1'b0, bin};
    case (state_q)
      StHaveA, StIssue, StWaitRes: begin
        disp_mode  = 2'd1;
        disp_value = op_a;
      end
      StShow: begin
        disp_mode  = 2'd2;
        disp_value = result_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with DB_CYCLES=4, RES_TIMEOUT=8 and a small
// ALU model that accepts immediately and answers two cycles after acceptance.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  bin = 10'd0;
  logic        buttonU = 1'b0, buttonR = 1'b0, buttonL = 1'b0;
  logic        op_valid, op_code, busy, err;
  logic        op_ready = 1'b1;
  logic [10:0] op_a, op_b, disp_value;
  logic [1:0]  disp_mode;
  logic        res_valid;
  logic [10:0] res_data;

  // ALU model state
  logic        alu_silent = 1'b0;
  logic        alu_rv = 1'b0;
  logic [10:0] alu_dat = '0;
  logic [1:0]  pv = '0;
  logic [10:0] pd [2];
  logic        tb_rv = 1'b0;
  logic [10:0] tb_dat = '0;
  int          hs_count = 0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  a;
    logic [9:0]  b;
    logic        sub;
    logic [10:0] exp_val;
  } vec_t;
  vec_t vecs [5];

  calc_sequencer #(.DB_CYCLES(4), .RES_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin       (bin),
    .buttonU   (buttonU),
    .buttonR   (buttonR),
    .buttonL   (buttonL),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_data  (res_data),
    .disp_value(disp_value),
    .disp_mode (disp_mode),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign res_valid = alu_rv | tb_rv;
  assign res_data  = tb_rv ? tb_dat : alu_dat;

  // ALU model: update away from the rising edge.
  always @(negedge clk) begin
    if (op_valid && op_ready) hs_count++;
    alu_rv  = pv[1];
    alu_dat = pd[1];
    pv[1]   = pv[0];
    pd[1]   = pd[0];
    pv[0]   = op_valid && op_ready && !alu_silent;
    pd[0]   = op_code ? (op_a - op_b) : (op_a + op_b);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [9:0] b, input logic u, input logic r, input logic l);
    @(negedge clk);
    bin = b;
    buttonU = u;
    buttonR = r;
    buttonL = l;
    repeat (10) @(negedge clk);
    buttonU = 1'b0;
    buttonR = 1'b0;
    buttonL = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int hs0;
    bit found;
    pd[0] = '0;
    pd[1] = '0;
    vecs[0] = '{a: 10'd100,  b: 10'd23,   sub: 1'b0, exp_val: 11'd123};
    vecs[1] = '{a: 10'd5,    b: 10'd20,   sub: 1'b1, exp_val: 11'h7F1};
    vecs[2] = '{a: 10'd1023, b: 10'd1023, sub: 1'b0, exp_val: 11'h7FE};
    vecs[3] = '{a: 10'd0,    b: 10'd1,    sub: 1'b1, exp_val: 11'h7FF};
    vecs[4] = '{a: 10'd512,  b: 10'd512,  sub: 1'b1, exp_val: 11'h000};

    // Reset state
    bin = 10'd300;
    repeat (3) @(negedge clk);
    check("rst_op_valid", 11'(op_valid), 11'd0);
    check("rst_busy", 11'(busy), 11'd0);
    check("rst_err", 11'(err), 11'd0);
    check("rst_mode", 11'(disp_mode), 11'd0);
    check("rst_op_a", op_a, 11'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_disp", disp_value, 11'd300);

    // Stray result strobe while idle is ignored
    tb_dat = 11'h055;
    tb_rv = 1'b1;
    @(negedge clk);
    tb_rv = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_res_mode", 11'(disp_mode), 11'd0);

    // Three-cycle glitch on U is not a press
    buttonU = 1'b1;
    repeat (3) @(negedge clk);
    buttonU = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_mode", 11'(disp_mode), 11'd0);

    // Table-driven operations
    for (int i = 0; i < 5; i++) begin
      press(vecs[i].a, 1'b1, 1'b0, 1'b0);
      check($sformatf("v%0d_save_mode", i), 11'(disp_mode), 11'd1);
      check($sformatf("v%0d_save_disp", i), disp_value, {1'b0, vecs[i].a});
      press(vecs[i].b, 1'b0, !vecs[i].sub, vecs[i].sub);
      check($sformatf("v%0d_mode", i), 11'(disp_mode), 11'd2);
      check($sformatf("v%0d_disp", i), disp_value, vecs[i].exp_val);
      check($sformatf("v%0d_op_a", i), op_a, {1'b0, vecs[i].a});
      check($sformatf("v%0d_op_b", i), op_b, {1'b0, vecs[i].b});
      check($sformatf("v%0d_op_code", i), 11'(op_code), 11'(vecs[i].sub));
      check($sformatf("v%0d_busy", i), 11'(busy), 11'd0);
    end

    // U and R together in HAVE_A: only a reload
    press(10'd7, 1'b1, 1'b0, 1'b0);
    hs0 = hs_count;
    press(10'd9, 1'b1, 1'b1, 1'b0);
    check("coinc_mode", 11'(disp_mode), 11'd1);
    check("coinc_disp", disp_value, 11'd9);
    check("coinc_no_req", 11'(hs_count - hs0), 11'd0);

    // Press L while showing 123
    press(10'd100, 1'b1, 1'b0, 1'b0);
    press(10'd23, 1'b0, 1'b1, 1'b0);
    check("chain_pre_disp", disp_value, 11'd123);
    press(10'd3, 1'b0, 1'b0, 1'b1);
    check("chain_mode", 11'(disp_mode), 11'd2);
`ifdef CALC_CHAIN_EN
    check("chain_disp", disp_value, 11'd120);
    check("chain_op_a", op_a, 11'd123);
    check("chain_op_b", op_b, 11'd3);
    check("chain_op_code", 11'(op_code), 11'd1);
`else
    check("chain_disp", disp_value, 11'd123);
    check("chain_op_a", op_a, 11'd100);
`endif

    // Result timeout
    press(10'd50, 1'b1, 1'b0, 1'b0);
    alu_silent = 1'b1;
    @(negedge clk);
    bin = 10'd60;
    buttonR = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (op_valid && op_ready) found = 1'b1;
    end
    check("tmo_handshake_seen", 11'(found), 11'd1);
    repeat (8) @(negedge clk);
    check("tmo_busy_last", 11'(busy), 11'd1);
    check("tmo_err_before", 11'(err), 11'd0);
    @(negedge clk);
    check("tmo_busy_after", 11'(busy), 11'd0);
    check("tmo_err", 11'(err), 11'd1);
    check("tmo_mode", 11'(disp_mode), 11'd0);
    buttonR = 1'b0;
    alu_silent = 1'b0;
    repeat (10) @(negedge clk);
    press(10'd61, 1'b1, 1'b0, 1'b0);
    check("tmo_err_clear", 11'(err), 11'd0);
    check("tmo_after_mode", 11'(disp_mode), 11'd1);

    // Reset while a request is pending; U held through reset
    op_ready = 1'b0;
    press(10'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bin = 10'd2;
    buttonR = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (op_valid) found = 1'b1;
    end
    check("mid_valid_seen", 11'(found), 11'd1);
    buttonU = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 11'(op_valid), 11'd0);
    check("mid_rst_busy", 11'(busy), 11'd0);
    check("mid_rst_disp", disp_value, 11'd2);
    rst = 1'b0;
    buttonR = 1'b0;
    op_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("held_u_mode", 11'(disp_mode), 11'd1);
    check("held_u_op_a", op_a, 11'd2);
    buttonU = 1'b0;
    repeat (10) @(negedge clk);
    check("held_u_no_req", 11'(busy), 11'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 500000: consecutive equal samples needed to accept a new debounced button level.
REQ-002 SHALL have parameter RES_TIMEOUT, default 255: maximum cycles spent in WAIT_RES before abort.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port bin  input  10  unsigned switch operand.
REQ-006 SHALL have ports buttonU, buttonR, buttonL  input  1 each  raw asynchronous buttons: save, add, subtract.
REQ-007 SHALL have port op_valid  output  1  ALU request valid.
REQ-008 SHALL have port op_ready  input  1  ALU accepts request.
REQ-009 SHALL have port op_code  output  1  0 = add, 1 = subtract.
REQ-010 SHALL have ports op_a, op_b  output  11 each  signed two's-complement operands.
REQ-011 SHALL have port res_valid  input  1  ALU result strobe.
REQ-012 SHALL have port res_data  input  11  signed ALU result.
REQ-013 SHALL have port disp_value  output  11  signed value for the display driver.
REQ-014 SHALL have port disp_mode  output  2  0 = live input, 1 = operand saved, 2 = result.
REQ-015 SHALL have ports busy and err  output  1 each  request in flight; result timeout occurred.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer, then a per-button counter that updates the debounced level only after DB_CYCLES consecutive samples differing from the current debounced level; any matching sample clears the counter.
REQ-017 A press SHALL be a one-cycle pulse on a debounced 0->1 transition, asserted no later than DB_CYCLES+3 cycles after a raw button rises and stays high.
REQ-018 When presses coincide in one cycle, priority SHALL be U > R > L; lower-priority presses that cycle are discarded.
REQ-019 FSM states SHALL be IDLE, HAVE_A, ISSUE, WAIT_RES, SHOW.
REQ-020 IDLE: disp_mode=0, disp_value={1'b0,bin}; U press -> op_a<={1'b0,bin}, err<=0, go to HAVE_A; R/L presses ignored.
REQ-021 HAVE_A: disp_mode=1, disp_value=op_a; U press -> reload op_a; R/L press -> op_b<={1'b0,bin}, op_code<=0/1 respectively, go to ISSUE.
REQ-022 ISSUE: op_valid=1 until the cycle where op_valid&&op_ready, then go to WAIT_RES; op_a, op_b, op_code SHALL be held stable while op_valid=1.
REQ-023 WAIT_RES: res_valid -> capture res_data as result, go to SHOW; if RES_TIMEOUT cycles elapse without res_valid -> err<=1, go to IDLE.
REQ-024 SHOW: disp_mode=2, disp_value=captured result; U press -> op_a<={1'b0,bin}, err<=0, go to HAVE_A; R/L behaviour per REQ-030.
REQ-025 busy SHALL be 1 exactly in ISSUE and WAIT_RES; all presses during busy are discarded, not queued.
REQ-026 res_valid outside WAIT_RES SHALL be ignored; a res_valid in the same cycle as the op_valid&&op_ready handshake SHALL be ignored.
REQ-027 Timeout counter SHALL reset on entry to WAIT_RES; res_valid in the final timeout cycle SHALL win over timeout.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE; op_valid, op_code, op_a, op_b, busy, err, and disp_mode = 0; result = 0; synchronizers, debounced levels, and counters = 0; disp_value follows IDLE rule from the next cycle.
REQ-029 rst mid-request SHALL drop op_valid immediately; a button held through reset SHALL yield exactly one press after DB_CYCLES.

Configuration
REQ-030 Macro CALC_CHAIN_EN: if defined, R/L press in SHOW -> op_a<=result, op_b<={1'b0,bin}, op_code set, go to ISSUE (chained operation); if undefined, R/L presses in SHOW are ignored.

Verification (DB_CYCLES=4, RES_TIMEOUT=8, ALU model op_ready=1, res_valid 2 cycles after accept)
REQ-031 bin=100, press U; bin=23, press R -> op_a=100, op_b=23, op_code=0; display disp_mode=2, disp_value=123.
REQ-032 bin=5, U; bin=20, L; ALU returns -15 -> disp_value=-15 (11'h7F1), disp_mode=2.
REQ-033 Raw buttonU glitch high for 3 cycles -> no press, state stays IDLE.
REQ-034 U and R rise in the same cycle while in HAVE_A -> only op_a reload, no request issued.
REQ-035 ALU never asserts res_valid -> err=1 and state IDLE exactly 8 cycles after entering WAIT_RES; next U press clears err.
REQ-036 With CALC_CHAIN_EN, result 123 shown, bin=3, press L -> op_a=123, op_b=3, disp_value=120; without the macro, state stays SHOW, disp_value=123.
